// File: rtl/odd_chk_rx_pkg.sv
// Shared definitions for the odd/even parity generator and checker pair:
// parity-mode encodings, default word width and receiver FSM states.
package odd_sel_pkg;

  localparam int DEF_DATA_W = 32;

  // sel encoding shared with the generator: XOR of data vs XNOR of data.
  localparam logic PAR_XOR  = 1'b1;
  localparam logic PAR_XNOR = 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2
  } rx_state_e;

endpackage

// File: rtl/odd_chk_rx_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (inc && (cnt != '1))
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/odd_chk_rx.sv
// Serial parity-checking receiver: deserializes DATA_W bits MSB first plus a
// trailing parity bit, flags mismatches and counts bad frames.
module odd_chk_rx
  import odd_sel_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sel,
  input  logic              din,
  input  logic              din_vld,
  input  logic              din_sof,
  input  logic              clr_cnt,
  output logic [DATA_W-1:0] dout,
  output logic              dout_vld,
  output logic              par_err,
  output logic              par_rx,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              busy
);

  localparam int BC_W = $clog2(DATA_W + 1);
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(DATA_W - 1);

  rx_state_e         state, state_nxt;
  logic [BC_W-1:0]   bit_cnt;
  logic [DATA_W-1:0] shift;
  logic              run_par;
  logic              sel_q;
  logic              start;
  logic              exp_par;

  // A flagged first bit restarts a frame from any state.
  assign start   = din_vld & din_sof;
  assign exp_par = (sel_q == PAR_XOR) ? run_par : ~run_par;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: default assignment first so every path drives state_nxt and no
  // latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = DATA;
      DATA:    if (start) state_nxt = DATA;
               else if (din_vld && (bit_cnt == LAST_BIT)) state_nxt = PAR;
      PAR:     if (start) state_nxt = DATA;
               else if (din_vld) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  // NOTE: the shift register is ordinary flops, so it is reset along with
  // the rest of the datapath; nothing here maps onto a RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt  <= '0;
      shift    <= '0;
      run_par  <= 1'b0;
      sel_q    <= 1'b0;
      dout     <= '0;
      dout_vld <= 1'b0;
      par_err  <= 1'b0;
      par_rx   <= 1'b0;
    end else begin
      dout_vld <= 1'b0;
      if (start) begin
        shift   <= {{(DATA_W-1){1'b0}}, din};
        run_par <= din;
        sel_q   <= sel;
        bit_cnt <= BC_W'(1);
      end else if (din_vld) begin
        case (state)
          DATA: begin
            shift   <= {shift[DATA_W-2:0], din};
            run_par <= run_par ^ din;
            bit_cnt <= bit_cnt + 1'b1;
          end
          PAR: begin
            dout     <= shift;
            par_rx   <= din;
            par_err  <= (din != exp_par);
            dout_vld <= 1'b1;
            bit_cnt  <= '0;
          end
          default: ;
        endcase
      end
    end
  end

  sat_cnt #(.W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (dout_vld & par_err),
    .clr   (clr_cnt),
    .cnt   (err_cnt)
  );

endmodule

// File: tb/tb_odd_chk_rx.sv
// Directed bench for odd_chk_rx: two instances share stimulus, one with an
// 8-bit error counter and one with a 2-bit counter for saturation.
module tb_odd_chk_rx;

  logic        clk = 1'b0;
  logic        rst_n, sel, din, din_vld, din_sof, clr_cnt;
  logic [31:0] dout, dout_b;
  logic        dout_vld, par_err, par_rx, busy;
  logic        vld_b, err_b, prx_b, busy_b;
  logic [7:0]  err_cnt;
  logic [1:0]  err_cnt_b;

  int n_pass = 0;
  int n_total = 0;
  int vld_seen = 0;

  logic        pb_vld, s_first_vld, s_pre_vld, s_vld, s_err, s_prx, s_vld_after;
  logic [31:0] pb_dout, s_first_dout, s_dout;
  logic [7:0]  s_cnt;
  logic [1:0]  s_cnt_b;

  always #5 clk = ~clk;

  odd_chk_rx #(.DATA_W(32), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .sel(sel), .din(din), .din_vld(din_vld),
    .din_sof(din_sof), .clr_cnt(clr_cnt), .dout(dout), .dout_vld(dout_vld),
    .par_err(par_err), .par_rx(par_rx), .err_cnt(err_cnt), .busy(busy)
  );

  odd_chk_rx #(.DATA_W(32), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .sel(sel), .din(din), .din_vld(din_vld),
    .din_sof(din_sof), .clr_cnt(clr_cnt), .dout(dout_b), .dout_vld(vld_b),
    .par_err(err_b), .par_rx(prx_b), .err_cnt(err_cnt_b), .busy(busy_b)
  );

  always @(negedge clk) if (dout_vld) vld_seen++;

  task automatic drive_bit(input logic b, input logic sof, input logic s);
    @(negedge clk);
    pb_vld  = dout_vld;
    pb_dout = dout;
    din = b; din_sof = sof; sel = s; din_vld = 1'b1;
  endtask

  task automatic idle();
    @(negedge clk);
    din_vld = 1'b0; din_sof = 1'b0;
  endtask

  // Drives 32 data bits MSB first then the parity bit (left on the bus).
  task automatic drive_frame(input logic [31:0] word, input logic par,
                             input logic s, input bit gaps, input int flip_at);
    for (int i = 0; i < 32; i++) begin
      if (gaps) for (int g = 0; g < i % 4; g++) idle();
      drive_bit(word[31-i], i == 0, (flip_at >= 0 && i >= flip_at) ? ~s : s);
      if (i == 0) begin
        s_first_vld  = pb_vld;
        s_first_dout = pb_dout;
      end
    end
    if (gaps) idle();
    drive_bit(par, 1'b0, s);
    s_pre_vld = pb_vld;
  endtask

  // Samples the dout_vld cycle (clr_cnt applied there), then the cycle after.
  task automatic finish_frame(input logic clr);
    @(negedge clk);
    s_vld = dout_vld; s_dout = dout; s_err = par_err; s_prx = par_rx;
    din_vld = 1'b0; din_sof = 1'b0; clr_cnt = clr;
    @(negedge clk);
    clr_cnt = 1'b0;
    s_vld_after = dout_vld; s_cnt = err_cnt; s_cnt_b = err_cnt_b;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sel = 1'b0; din = 1'b0; din_vld = 1'b0; din_sof = 1'b0; clr_cnt = 1'b0;
    #12;
    n_total++; if (dout !== 32'h0) $display("FAIL reset_dout got %h exp %h", dout, 32'h0); else n_pass++;
    n_total++; if ({dout_vld, par_err, par_rx, busy} !== 4'b0) $display("FAIL reset_flags got %b exp 0000", {dout_vld, par_err, par_rx, busy}); else n_pass++;
    n_total++; if (err_cnt !== 8'd0) $display("FAIL reset_cnt got %0d exp 0", err_cnt); else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy_after got %b exp 0", busy); else n_pass++;
  endtask

  task automatic test_basic();
    drive_frame(32'h0000_0001, 1'b1, 1'b1, 1'b0, -1);
    finish_frame(1'b0);
    n_total++; if (s_pre_vld !== 1'b0) $display("FAIL basic_early_vld got %b exp 0", s_pre_vld); else n_pass++;
    n_total++; if (s_vld !== 1'b1) $display("FAIL basic_vld got %b exp 1", s_vld); else n_pass++;
    n_total++; if (s_dout !== 32'h0000_0001) $display("FAIL basic_dout got %h exp 00000001", s_dout); else n_pass++;
    n_total++; if (s_err !== 1'b0) $display("FAIL basic_err got %b exp 0", s_err); else n_pass++;
    n_total++; if (s_prx !== 1'b1) $display("FAIL basic_par_rx got %b exp 1", s_prx); else n_pass++;
    n_total++; if (s_vld_after !== 1'b0) $display("FAIL basic_vld_pulse got %b exp 0", s_vld_after); else n_pass++;
    n_total++; if (s_cnt !== 8'd0) $display("FAIL basic_cnt got %0d exp 0", s_cnt); else n_pass++;
  endtask

  task automatic test_bad_parity();
    drive_frame(32'h0000_0001, 1'b0, 1'b1, 1'b0, -1);
    finish_frame(1'b0);
    n_total++; if (s_err !== 1'b1) $display("FAIL bad_err got %b exp 1", s_err); else n_pass++;
    n_total++; if (s_prx !== 1'b0) $display("FAIL bad_par_rx got %b exp 0", s_prx); else n_pass++;
    n_total++; if (s_cnt !== 8'd1) $display("FAIL bad_cnt got %0d exp 1", s_cnt); else n_pass++;
    drive_frame(32'h0000_0001, 1'b1, 1'b1, 1'b0, -1);
    finish_frame(1'b0);
    n_total++; if (s_err !== 1'b0) $display("FAIL good_after_bad_err got %b exp 0", s_err); else n_pass++;
    n_total++; if (s_cnt !== 8'd1) $display("FAIL good_after_bad_cnt got %0d exp 1", s_cnt); else n_pass++;
  endtask

  task automatic test_xnor_mode();
    drive_frame(32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, -1);
    finish_frame(1'b0);
    n_total++; if (s_err !== 1'b0) $display("FAIL xnor_err got %b exp 0", s_err); else n_pass++;
    n_total++; if (s_dout !== 32'hFFFF_FFFF) $display("FAIL xnor_dout got %h exp ffffffff", s_dout); else n_pass++;
    drive_frame(32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 10);
    finish_frame(1'b0);
    n_total++; if (s_err !== 1'b0) $display("FAIL sel_flip_err got %b exp 0", s_err); else n_pass++;
    n_total++; if (s_cnt !== 8'd1) $display("FAIL sel_flip_cnt got %0d exp 1", s_cnt); else n_pass++;
  endtask

  task automatic test_gaps();
    vld_seen = 0;
    drive_frame(32'hA5A5_5A5A, 1'b0, 1'b1, 1'b1, -1);
    finish_frame(1'b0);
    n_total++; if (s_dout !== 32'hA5A5_5A5A) $display("FAIL gaps_dout got %h exp a5a55a5a", s_dout); else n_pass++;
    n_total++; if (s_err !== 1'b0) $display("FAIL gaps_err got %b exp 0", s_err); else n_pass++;
    n_total++; if (vld_seen !== 1) $display("FAIL gaps_vld_count got %0d exp 1", vld_seen); else n_pass++;
  endtask

  task automatic test_abort();
    vld_seen = 0;
    for (int i = 0; i < 12; i++) drive_bit(1'b1, i == 0, 1'b0);
    idle();
    n_total++; if (busy !== 1'b1) $display("FAIL abort_busy got %b exp 1", busy); else n_pass++;
    drive_frame(32'h1234_5678, 1'b1, 1'b1, 1'b0, -1);
    finish_frame(1'b0);
    n_total++; if (vld_seen !== 1) $display("FAIL abort_vld_count got %0d exp 1", vld_seen); else n_pass++;
    n_total++; if (s_dout !== 32'h1234_5678) $display("FAIL abort_dout got %h exp 12345678", s_dout); else n_pass++;
    n_total++; if (s_err !== 1'b0) $display("FAIL abort_err got %b exp 0", s_err); else n_pass++;
    n_total++; if (s_cnt !== 8'd1) $display("FAIL abort_cnt got %0d exp 1", s_cnt); else n_pass++;
  endtask

  task automatic test_back_to_back();
    vld_seen = 0;
    drive_frame(32'h0F0F_0F0F, 1'b0, 1'b1, 1'b0, -1);
    drive_frame(32'h1234_5678, 1'b1, 1'b1, 1'b0, -1);
    finish_frame(1'b0);
    n_total++; if (s_first_vld !== 1'b1) $display("FAIL b2b_first_vld got %b exp 1", s_first_vld); else n_pass++;
    n_total++; if (s_first_dout !== 32'h0F0F_0F0F) $display("FAIL b2b_first_dout got %h exp 0f0f0f0f", s_first_dout); else n_pass++;
    n_total++; if (s_dout !== 32'h1234_5678) $display("FAIL b2b_second_dout got %h exp 12345678", s_dout); else n_pass++;
    n_total++; if (vld_seen !== 2) $display("FAIL b2b_vld_count got %0d exp 2", vld_seen); else n_pass++;
  endtask

  task automatic test_reset_midframe();
    for (int i = 0; i < 8; i++) drive_bit(1'b1, i == 0, 1'b1);
    @(negedge clk);
    din_vld = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_total++; if (dout !== 32'h0) $display("FAIL midrst_dout got %h exp 0", dout); else n_pass++;
    n_total++; if ({dout_vld, par_err, par_rx, busy} !== 4'b0) $display("FAIL midrst_flags got %b exp 0000", {dout_vld, par_err, par_rx, busy}); else n_pass++;
    n_total++; if (err_cnt !== 8'd0) $display("FAIL midrst_cnt got %0d exp 0", err_cnt); else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    vld_seen = 0;
    repeat (40) idle();
    n_total++; if (vld_seen !== 0) $display("FAIL midrst_no_vld got %0d exp 0", vld_seen); else n_pass++;
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 5; k++) begin
      drive_frame(32'h0000_0001, 1'b0, 1'b1, 1'b0, -1);
      finish_frame(1'b0);
      n_total++;
      if (s_cnt_b !== 2'((k + 1 > 3) ? 3 : k + 1))
        $display("FAIL sat_cnt_%0d got %0d exp %0d", k, s_cnt_b, (k + 1 > 3) ? 3 : k + 1);
      else n_pass++;
    end
    n_total++; if (s_cnt !== 8'd5) $display("FAIL sat_wide_cnt got %0d exp 5", s_cnt); else n_pass++;
    drive_frame(32'h0000_0001, 1'b0, 1'b1, 1'b0, -1);
    finish_frame(1'b1);
    n_total++; if (s_err !== 1'b1) $display("FAIL clr_err got %b exp 1", s_err); else n_pass++;
    n_total++; if (s_cnt_b !== 2'd0) $display("FAIL clr_cnt_narrow got %0d exp 0", s_cnt_b); else n_pass++;
    n_total++; if (s_cnt !== 8'd0) $display("FAIL clr_cnt_wide got %0d exp 0", s_cnt); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_parity();
    test_xnor_mode();
    test_gaps();
    test_abort();
    test_back_to_back();
    test_reset_midframe();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
